// File: rtl/controle_multiciclo_pkg.sv
// Shared types and width helpers for the multi-cycle control unit.
// Optional stall support is selected with the CONTROLE_STALL_EN macro.
package controle_multiciclo_pkg;

   typedef enum logic [1:0] {
      StT0 = 2'b00,
      StT1 = 2'b01,
      StT2 = 2'b10,
      StT3 = 2'b11
   } state_e;

   typedef enum logic [2:0] {
      OpAdd = 3'b000,
      OpSub = 3'b001,
      OpNan = 3'b010,
      OpRsv = 3'b011,
      OpOut = 3'b100,
      OpLdi = 3'b101,
      OpMv  = 3'b110,
      OpRep = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      AluAdd  = 2'b00,
      AluSub  = 2'b01,
      AluNand = 2'b10
   } alu_op_e;

   function automatic int unsigned reg_sel_w(input int unsigned num_regs);
      return $clog2(num_regs);
   endfunction

   function automatic int unsigned iin_w(input int unsigned num_regs);
      return 3 + 2 * $clog2(num_regs);
   endfunction

   function automatic int unsigned mux_w(input int unsigned num_regs);
      return $clog2(num_regs + 2);
   endfunction

   function automatic int unsigned mux_din(input int unsigned num_regs);
      return num_regs;
   endfunction

   function automatic int unsigned mux_g(input int unsigned num_regs);
      return num_regs + 1;
   endfunction

   // ADD/SUB/NAN share the three-step A -> G -> write-back sequence.
   function automatic logic is_alu(input logic [2:0] op);
      return (op == OpAdd) || (op == OpSub) || (op == OpNan);
   endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Instruction-source / datapath-control bundle of the multi-cycle control unit.
// With CONTROLE_STALL_EN defined the bundle also carries the stall request.
interface controle_multiciclo_if #(
   parameter int unsigned NUM_REGS = 8
) ();
   import controle_multiciclo_pkg::*;

   localparam int unsigned REG_SEL_W = reg_sel_w(NUM_REGS);
   localparam int unsigned IIN_W     = iin_w(NUM_REGS);
   localparam int unsigned MUX_W     = mux_w(NUM_REGS);

   logic                 run;
   logic [IIN_W-1:0]     iin;
   logic [MUX_W-1:0]     mux_select;
   logic [NUM_REGS-1:0]  regs_enable;
   logic                 a_enable;
   logic                 g_enable;
   logic [1:0]           alu_op_select;
   logic                 out_enable;
   logic                 done;

`ifdef CONTROLE_STALL_EN
   logic                 stall;

   modport master (
      output run, iin, stall,
      input  mux_select, regs_enable, a_enable, g_enable, alu_op_select, out_enable, done
   );

   modport slave (
      input  run, iin, stall,
      output mux_select, regs_enable, a_enable, g_enable, alu_op_select, out_enable, done
   );
`else
   modport master (
      output run, iin,
      input  mux_select, regs_enable, a_enable, g_enable, alu_op_select, out_enable, done
   );

   modport slave (
      input  run, iin,
      output mux_select, regs_enable, a_enable, g_enable, alu_op_select, out_enable, done
   );
`endif

endinterface

// File: rtl/controle_multiciclo_decodificador.sv
// Register-select decoder: rx field to one-hot write enable, gated by the write step.
module decodificador_param #(
   parameter int unsigned NUM_REGS = 8,
   localparam int unsigned SelW = $clog2(NUM_REGS)
) (
   input  logic [SelW-1:0]     sel_i,
   input  logic                en_i,
   output logic [NUM_REGS-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit: T0..T3 step counter, instruction register and Moore output decode.
// Defining CONTROLE_STALL_EN adds a stall input that freezes the step and masks all strobes.
module controle_multiciclo
   import controle_multiciclo_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8
) (
   input logic                  clock,
   input logic                  reset,
   controle_multiciclo_if.slave bus
);

   localparam int unsigned REG_SEL_W = reg_sel_w(NUM_REGS);
   localparam int unsigned IIN_W     = iin_w(NUM_REGS);
   localparam int unsigned MUX_W     = mux_w(NUM_REGS);

   localparam logic [MUX_W-1:0] MuxDin = MUX_W'(mux_din(NUM_REGS));
   localparam logic [MUX_W-1:0] MuxG   = MUX_W'(mux_g(NUM_REGS));

   state_e               state_q, state_d;
   logic [IIN_W-1:0]     ir_q, ir_d;
   logic                 ir_valid_q, ir_valid_d;
   // Set when the instruction in flight is a NOP (reserved opcode or REP with nothing to replay).
   logic                 nop_q, nop_d;

   logic                 stall;
   logic [2:0]           iin_op;
   logic [2:0]           ir_op;
   logic [REG_SEL_W-1:0] ir_rx;
   logic [REG_SEL_W-1:0] ir_ry;

   logic [MUX_W-1:0]     mux_sel;
   logic                 wr_step;
   logic                 a_en;
   logic                 g_en;
   logic [1:0]           alu_op;
   logic                 out_en;
   logic                 done_p;
   logic [NUM_REGS-1:0]  regs_en;

`ifdef CONTROLE_STALL_EN
   assign stall = bus.stall;
`else
   assign stall = 1'b0;
`endif

   assign iin_op = bus.iin[IIN_W-1 -: 3];
   assign ir_op  = ir_q[IIN_W-1 -: 3];
   assign ir_rx  = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
   assign ir_ry  = ir_q[REG_SEL_W-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StT0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         nop_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         nop_q      <= nop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      nop_d      = nop_q;
      if (!stall) begin
         unique case (state_q)
            StT0: begin
               if (bus.run) begin
                  state_d = StT1;
                  // REP keeps the held IR and replays it.
                  if (iin_op == OpRep) begin
                     nop_d = !ir_valid_q || (ir_op == OpRsv);
                  end else begin
                     ir_d       = bus.iin;
                     ir_valid_d = 1'b1;
                     nop_d      = (iin_op == OpRsv);
                  end
               end
            end
            StT1:    state_d = (is_alu(ir_op) && !nop_q) ? StT2 : StT0;
            StT2:    state_d = StT3;
            StT3:    state_d = StT0;
            default: state_d = StT0;
         endcase
      end
   end

   always_comb begin
      mux_sel = '0;
      wr_step = 1'b0;
      a_en    = 1'b0;
      g_en    = 1'b0;
      alu_op  = AluAdd;
      out_en  = 1'b0;
      done_p  = 1'b0;
      unique case (state_q)
         StT1: begin
            if (nop_q) begin
               done_p = 1'b1;
            end else begin
               unique case (ir_op)
                  OpMv: begin
                     mux_sel = MUX_W'(ir_ry);
                     wr_step = 1'b1;
                     done_p  = 1'b1;
                  end
                  OpLdi: begin
                     mux_sel = MuxDin;
                     wr_step = 1'b1;
                     done_p  = 1'b1;
                  end
                  OpOut: begin
                     mux_sel = MUX_W'(ir_ry);
                     out_en  = 1'b1;
                     done_p  = 1'b1;
                  end
                  default: begin
                     mux_sel = MUX_W'(ir_rx);
                     a_en    = 1'b1;
                  end
               endcase
            end
         end
         StT2: begin
            mux_sel = MUX_W'(ir_ry);
            g_en    = 1'b1;
            alu_op  = ir_op[1:0];
         end
         StT3: begin
            mux_sel = MuxG;
            wr_step = 1'b1;
            done_p  = 1'b1;
         end
         default: ;
      endcase
      if (stall) begin
         wr_step = 1'b0;
         a_en    = 1'b0;
         g_en    = 1'b0;
         alu_op  = AluAdd;
         out_en  = 1'b0;
         done_p  = 1'b0;
      end
   end

   decodificador_param #(
      .NUM_REGS (NUM_REGS)
   ) u_dec (
      .sel_i    (ir_rx),
      .en_i     (wr_step),
      .onehot_o (regs_en)
   );

   assign bus.mux_select    = mux_sel;
   assign bus.regs_enable   = regs_en;
   assign bus.a_enable      = a_en;
   assign bus.g_enable      = g_en;
   assign bus.alu_op_select = alu_op;
   assign bus.out_enable    = out_en;
   assign bus.done          = done_p;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo (8- and 16-register instances).
// Stall scenarios are exercised only when CONTROLE_STALL_EN is defined.
module tb_controle_multiciclo;

   typedef struct packed {
      logic [3:0] mux;
      logic [7:0] regs;
      logic       a;
      logic       g;
      logic [1:0] alu;
      logic       out;
      logic       done;
   } ovec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int errors = 0;
   int checks = 0;

   // Reference model state: last non-REP instruction and whether one exists.
   logic [8:0] m_ir;
   logic       m_valid;
   ovec_t      exp_seq [4];
   int         exp_n;
   logic [8:0] dir_tbl [10];

   always #5 clock = ~clock;

   controle_multiciclo_if #(.NUM_REGS(8))  bus8 ();
   controle_multiciclo_if #(.NUM_REGS(16)) bus16 ();

   controle_multiciclo #(.NUM_REGS(8)) u_dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (bus8)
   );

   controle_multiciclo #(.NUM_REGS(16)) u_dut16 (
      .clock (clock),
      .reset (reset),
      .bus   (bus16)
   );

   function automatic ovec_t obs();
      ovec_t v;
      v.mux  = bus8.mux_select;
      v.regs = bus8.regs_enable;
      v.a    = bus8.a_enable;
      v.g    = bus8.g_enable;
      v.alu  = bus8.alu_op_select;
      v.out  = bus8.out_enable;
      v.done = bus8.done;
      return v;
   endfunction

   // Expected per-step outputs (T1 onward) of one issued instruction.
   task automatic model_issue(input logic [8:0] instr);
      logic [8:0] e;
      ovec_t      v;
      e = instr;
      if (instr[8:6] == 3'b111) begin
         e = m_valid ? m_ir : 9'b011_000_000;
      end else begin
         m_ir    = instr;
         m_valid = 1'b1;
      end
      for (int i = 0; i < 4; i++) exp_seq[i] = '0;
      v = '0;
      case (e[8:6])
         3'b000, 3'b001, 3'b010: begin
            v.mux = {1'b0, e[5:3]}; v.a = 1'b1; exp_seq[0] = v;
            v = '0;
            v.mux = {1'b0, e[2:0]}; v.g = 1'b1; v.alu = e[7:6]; exp_seq[1] = v;
            v = '0;
            v.mux = 4'd9; v.regs = 8'd1 << e[5:3]; v.done = 1'b1; exp_seq[2] = v;
            exp_n = 3;
         end
         3'b100: begin
            v.mux = {1'b0, e[2:0]}; v.out = 1'b1; v.done = 1'b1; exp_seq[0] = v; exp_n = 1;
         end
         3'b101: begin
            v.mux = 4'd8; v.regs = 8'd1 << e[5:3]; v.done = 1'b1; exp_seq[0] = v; exp_n = 1;
         end
         3'b110: begin
            v.mux = {1'b0, e[2:0]}; v.regs = 8'd1 << e[5:3]; v.done = 1'b1; exp_seq[0] = v;
            exp_n = 1;
         end
         default: begin
            v.done = 1'b1; exp_seq[0] = v; exp_n = 1;
         end
      endcase
   endtask

   task automatic test_reset();
      bus8.run = 1'b1;
      reset    = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus8.iin = 9'($urandom);
         @(posedge clock); #1;
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h expected 0", c, obs());
         end
      end
      reset    = 1'b0;
      bus8.run = 1'b0;
      m_valid  = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL reset_idle: got %h expected 0", obs());
      end
   endtask

   // Run held high throughout, then one idle T0 cycle: nothing may be queued.
   task automatic test_directed();
      ovec_t got;
      dir_tbl = '{9'b111_000_000, 9'b101_011_000, 9'b000_001_010, 9'b001_101_110,
                  9'b111_000_000, 9'b100_000_111, 9'b011_010_001, 9'b111_000_000,
                  9'b110_100_100, 9'b010_011_011};
      for (int i = 0; i < 10; i++) begin
         bus8.run = 1'b1;
         bus8.iin = dir_tbl[i];
         model_issue(dir_tbl[i]);
         for (int k = 0; k < exp_n; k++) begin
            @(posedge clock); #1;
            got = obs();
            checks++;
            if (got !== exp_seq[k]) begin
               errors++;
               $display("FAIL directed[%0d] step %0d: got %h expected %h", i, k + 1, got,
                        exp_seq[k]);
            end
         end
         @(posedge clock); #1;
         bus8.run = 1'b0;
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL directed[%0d] back_to_t0: got %h expected 0", i, obs());
         end
         @(posedge clock); #1;
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL directed[%0d] idle: got %h expected 0", i, obs());
         end
      end
   endtask

   task automatic test_reset_abort();
      ovec_t got;
      bus8.run = 1'b1;
      bus8.iin = 9'b000_001_010;
      model_issue(9'b000_001_010);
      for (int k = 0; k < 2; k++) begin
         @(posedge clock); #1;
         checks++;
         if (obs() !== exp_seq[k]) begin
            errors++;
            $display("FAIL abort step %0d: got %h expected %h", k + 1, obs(), exp_seq[k]);
         end
      end
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clock); #1;
         got = obs();
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL abort_reset cycle %0d: got %h expected 0", c, got);
         end
      end
      reset    = 1'b0;
      bus8.run = 1'b0;
      m_valid  = 1'b0;
      @(posedge clock); #1;
      // Reset also forgets the held instruction: REP now degenerates to NOP.
      bus8.run = 1'b1;
      bus8.iin = 9'b111_101_010;
      model_issue(9'b111_101_010);
      @(posedge clock); #1;
      bus8.run = 1'b0;
      checks++;
      if (obs() !== exp_seq[0]) begin
         errors++;
         $display("FAIL abort_rep: got %h expected %h", obs(), exp_seq[0]);
      end
      @(posedge clock); #1;
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL abort_rep_t0: got %h expected 0", obs());
      end
   endtask

   task automatic test_random();
      ovec_t      got;
      logic [8:0] instr;
      for (int i = 0; i < 60; i++) begin
         bus8.run = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
         end
         instr    = 9'($urandom);
         bus8.run = 1'b1;
         bus8.iin = instr;
         model_issue(instr);
         for (int k = 0; k < exp_n; k++) begin
            @(posedge clock); #1;
            bus8.run = 1'($urandom);
            bus8.iin = 9'($urandom);
            got = obs();
            checks++;
            if (got !== exp_seq[k]) begin
               errors++;
               $display("FAIL random[%0d] instr %b step %0d: got %h expected %h", i, instr,
                        k + 1, got, exp_seq[k]);
            end
         end
         @(posedge clock); #1;
         bus8.run = 1'b0;
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL random[%0d] back_to_t0: got %h expected 0", i, obs());
         end
      end
   endtask

   task automatic test_regs16();
      bus16.run = 1'b1;
      bus16.iin = {3'b110, 4'd15, 4'd0};
      @(posedge clock); #1;
      bus16.run = 1'b0;
      checks++;
      if (bus16.regs_enable !== 16'h8000 || bus16.mux_select !== 5'd0 || bus16.done !== 1'b1)
      begin
         errors++;
         $display("FAIL regs16_mv: got regs %h mux %0d done %b expected 8000 0 1",
                  bus16.regs_enable, bus16.mux_select, bus16.done);
      end
      @(posedge clock); #1;
      bus16.run = 1'b1;
      bus16.iin = {3'b001, 4'd15, 4'd15};
      @(posedge clock); #1;
      bus16.run = 1'b0;
      checks++;
      if (bus16.a_enable !== 1'b1 || bus16.mux_select !== 5'd15) begin
         errors++;
         $display("FAIL regs16_t1: got a %b mux %0d expected 1 15", bus16.a_enable,
                  bus16.mux_select);
      end
      @(posedge clock); #1;
      checks++;
      if (bus16.g_enable !== 1'b1 || bus16.alu_op_select !== 2'b01) begin
         errors++;
         $display("FAIL regs16_t2: got g %b alu %b expected 1 01", bus16.g_enable,
                  bus16.alu_op_select);
      end
      @(posedge clock); #1;
      checks++;
      if (bus16.regs_enable !== 16'h8000 || bus16.mux_select !== 5'd17 || bus16.done !== 1'b1)
      begin
         errors++;
         $display("FAIL regs16_t3: got regs %h mux %0d done %b expected 8000 17 1",
                  bus16.regs_enable, bus16.mux_select, bus16.done);
      end
      @(posedge clock); #1;
   endtask

`ifdef CONTROLE_STALL_EN
   task automatic test_stall();
      ovec_t got;
      // Stall in T0 must keep run from being accepted.
      bus8.stall = 1'b1;
      bus8.run   = 1'b1;
      bus8.iin   = 9'b000_001_010;
      model_issue(9'b000_001_010);
      repeat (2) begin
         @(posedge clock); #1;
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL stall_t0: got %h expected 0", obs());
         end
      end
      bus8.stall = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clock); #1;
         bus8.run = 1'b0;
         checks++;
         if (obs() !== exp_seq[k]) begin
            errors++;
            $display("FAIL stall_pre step %0d: got %h expected %h", k + 1, obs(), exp_seq[k]);
         end
      end
      bus8.stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         got = obs();
         checks++;
         if (got.g !== 1'b0 || got.done !== 1'b0 || got.regs !== 8'h00 || got.alu !== 2'b00)
         begin
            errors++;
            $display("FAIL stall_t2 cycle %0d: got %h expected no strobes", c, got);
         end
         @(posedge clock); #1;
      end
      bus8.stall = 1'b0;
      #1;
      checks++;
      if (obs() !== exp_seq[1]) begin
         errors++;
         $display("FAIL stall_reissue: got %h expected %h", obs(), exp_seq[1]);
      end
      @(posedge clock); #1;
      checks++;
      if (obs() !== exp_seq[2]) begin
         errors++;
         $display("FAIL stall_t3: got %h expected %h", obs(), exp_seq[2]);
      end
      @(posedge clock); #1;
      // 16-register instance: stalled write step, then released.
      bus16.run = 1'b1;
      bus16.iin = {3'b110, 4'd15, 4'd3};
      @(posedge clock); #1;
      bus16.run   = 1'b0;
      bus16.stall = 1'b1;
      repeat (2) begin
         #1;
         checks++;
         if (bus16.regs_enable !== 16'h0000 || bus16.done !== 1'b0) begin
            errors++;
            $display("FAIL stall16_hold: got regs %h done %b expected 0000 0",
                     bus16.regs_enable, bus16.done);
         end
         @(posedge clock); #1;
      end
      bus16.stall = 1'b0;
      #1;
      checks++;
      if (bus16.regs_enable !== 16'h8000 || bus16.done !== 1'b1) begin
         errors++;
         $display("FAIL stall16_release: got regs %h done %b expected 8000 1",
                  bus16.regs_enable, bus16.done);
      end
      @(posedge clock); #1;
   endtask
`endif

   initial begin
      bus8.run  = 1'b0;
      bus8.iin  = '0;
      bus16.run = 1'b0;
      bus16.iin = '0;
`ifdef CONTROLE_STALL_EN
      bus8.stall  = 1'b0;
      bus16.stall = 1'b0;
`endif
      m_ir    = '0;
      m_valid = 1'b0;
      test_reset();
      test_directed();
      test_reset_abort();
      test_random();
      test_regs16();
`ifdef CONTROLE_STALL_EN
      test_stall();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
